// File: rtl/dds_pkg.sv
// dds_pkg: shared constants and elaboration-time sine table math for dds_sine_gen.
// Build option: DDS_QUARTER_WAVE_EN selects the quarter-wave ROM layout.
package dds_pkg;

  // Phase-address quadrant field: bit 0 mirrors the index, bit 1 negates the sample
  localparam int QUAD_MIRROR_BIT = 0;
  localparam int QUAD_NEG_BIT    = 1;

  // Peak amplitude: largest positive signed value that fits in dw bits
  function automatic int amp(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  // First-quadrant entry T[k], k = 0..Q, rounded half away from zero (value is >= 0)
  function automatic int quarter_entry(input int k, input int aw, input int dw);
    real r;
    r = real'(amp(dw)) * $sin(3.14159265358979 * real'(k) / (2.0 * real'(1 << (aw - 2))));
    return $rtoi(r + 0.5);
  endfunction

  // Full-table entry built by mirroring T, so the symmetry points are exact
  function automatic int lut_entry(input int i, input int aw, input int dw);
    int         q;
    int         k;
    int         v;
    logic [1:0] quad;
    q    = 1 << (aw - 2);
    k    = i % q;
    quad = 2'((i >> (aw - 2)) & 3);
    v    = quarter_entry(quad[QUAD_MIRROR_BIT] ? q - k : k, aw, dw);
    return quad[QUAD_NEG_BIT] ? -v : v;
  endfunction

  // ROM index width: quarter-wave needs 0..Q, i.e. one bit less than the phase address
  function automatic int rom_idx_w(input int aw);
`ifdef DDS_QUARTER_WAVE_EN
    return aw - 1;
`else
    return aw;
`endif
  endfunction

endpackage

// File: rtl/dds_sine_rom.sv
// dds_sine_rom: registered-read signed sine ROM, one-cycle latency.
// DDS_QUARTER_WAVE_EN: Q+1 entries plus output negation; otherwise full 2^ADDR_W table.
module dds_sine_rom
  import dds_pkg::*;
#(
  parameter  int ADDR_W = 8,
  parameter  int DATA_W = 8,
  localparam int IDX_W  = rom_idx_w(ADDR_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IDX_W-1:0]         idx,
  input  logic                     neg,
  output logic signed [DATA_W-1:0] sample
);

`ifdef DDS_QUARTER_WAVE_EN
  localparam int DEPTH = (1 << (ADDR_W - 2)) + 1;
`else
  localparam int DEPTH = 1 << ADDR_W;
`endif

  logic signed [DATA_W-1:0] rom [DEPTH];
  logic signed [DATA_W-1:0] rd;

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
`ifdef DDS_QUARTER_WAVE_EN
    assign rom[i] = DATA_W'(quarter_entry(i, ADDR_W, DATA_W));
`else
    assign rom[i] = DATA_W'(lut_entry(i, ADDR_W, DATA_W));
`endif
  end

  assign rd = rom[idx];

  // Registered read; negation only ever set in the quarter-wave build
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sample <= '0;
    else     sample <= neg ? -rd : rd;
  end

endmodule

// File: rtl/dds_sine_gen.sv
// dds_sine_gen: DDS sine source. ftw register, phase accumulator with sync clear,
// phase offset, P1 address register, P2 ROM read; wrap and valid flags.
// Build option: DDS_QUARTER_WAVE_EN (quarter-wave ROM, identical output stream).
module dds_sine_gen
  import dds_pkg::*;
#(
  parameter int PHASE_W = 24,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     ftw_load,
  input  logic [PHASE_W-1:0]       ftw_i,
  input  logic [PHASE_W-1:0]       phase_off_i,
  input  logic                     sync_clr,
  output logic signed [DATA_W-1:0] sample_o,
  output logic                     valid_o,
  output logic                     wrap_o
);

  localparam int IDX_W = rom_idx_w(ADDR_W);

  logic [PHASE_W-1:0] ftw_q;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W:0]   acc_sum;
  logic [PHASE_W-1:0] phase;
  logic [ADDR_W-1:0]  addr;
  logic [IDX_W-1:0]   idx_d, idx_q;
  logic               neg_d, neg_q;
  logic               step;
  logic [2:1]         vld_pipe;

  // Carry out of acc_sum is the wrap condition
  assign acc_sum = {1'b0, acc} + {1'b0, ftw_q};
  assign phase   = acc + phase_off_i;
  assign addr    = phase[PHASE_W-1 -: ADDR_W];
  assign step    = en & ~sync_clr;

`ifdef DDS_QUARTER_WAVE_EN
  localparam logic [IDX_W-1:0] Q_IDX = IDX_W'(1 << (ADDR_W - 2));
  logic [1:0]        quad;
  logic [ADDR_W-3:0] k;

  // Fold the phase address into first-quadrant index plus sign
  always_comb begin
    quad  = addr[ADDR_W-1 -: 2];
    k     = addr[ADDR_W-3:0];
    idx_d = quad[QUAD_MIRROR_BIT] ? Q_IDX - {1'b0, k} : {1'b0, k};
    neg_d = quad[QUAD_NEG_BIT];
  end
`else
  // Full table: address used directly, never negated
  always_comb begin
    idx_d = addr;
    neg_d = 1'b0;
  end
`endif

  // Tuning word, accumulator, wrap flag, P1 registers and valid pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ftw_q    <= '0;
      acc      <= '0;
      wrap_o   <= 1'b0;
      idx_q    <= '0;
      neg_q    <= 1'b0;
      vld_pipe <= '0;
    end else begin
      if (ftw_load) ftw_q <= ftw_i;
      if (sync_clr) acc <= '0;
      else if (en)  acc <= acc_sum[PHASE_W-1:0];
      wrap_o   <= step & acc_sum[PHASE_W];
      idx_q    <= idx_d;
      neg_q    <= neg_d;
      vld_pipe <= {vld_pipe[1], step};
    end
  end

  assign valid_o = vld_pipe[2];

  dds_sine_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rom (
    .clk    (clk),
    .rst    (rst),
    .idx    (idx_q),
    .neg    (neg_q),
    .sample (sample_o)
  );

endmodule

// File: tb/tb_dds_sine_gen.sv
// tb_dds_sine_gen: self-checking bench for dds_sine_gen (PHASE_W=ADDR_W=DATA_W=8).
module tb_dds_sine_gen;

  localparam int PW = 8;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MOD = 1 << PW;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en = 1'b0;
  logic                 ftw_load = 1'b0;
  logic                 sync_clr = 1'b0;
  logic [PW-1:0]        ftw_i = '0;
  logic [PW-1:0]        phase_off_i = '0;
  logic signed [DW-1:0] sample_o;
  logic                 valid_o;
  logic                 wrap_o;

  dds_sine_gen #(.PHASE_W(PW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .ftw_load    (ftw_load),
    .ftw_i       (ftw_i),
    .phase_off_i (phase_off_i),
    .sync_clr    (sync_clr),
    .sample_o    (sample_o),
    .valid_o     (valid_o),
    .wrap_o      (wrap_o)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model: phase accumulator and the sample/valid expected one edge later
  int m_acc, m_ftw, m_ps, m_pv;
  int exp_s, exp_v, exp_w;

  typedef struct {
    int off;
    int exp_sample;
  } vec_t;

  // Ideal sine sample straight from the defining formula
  function automatic int lut(input int i);
    real r;
    r = 127.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 256.0);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else          return -$rtoi(-r + 0.5);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_ftw = 0; m_ps = 0; m_pv = 0;
  endtask

  task automatic model_edge();
    int ph;
    exp_s = m_ps;
    exp_v = m_pv;
    ph    = (m_acc + int'(phase_off_i)) % MOD;
    m_ps  = lut(ph >> (PW - AW));
    m_pv  = (en && !sync_clr) ? 1 : 0;
    exp_w = (en && !sync_clr && (m_acc + m_ftw >= MOD)) ? 1 : 0;
    if (sync_clr) m_acc = 0;
    else if (en)  m_acc = (m_acc + m_ftw) % MOD;
    if (ftw_load) m_ftw = int'(ftw_i);
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("sample", int'(sample_o), exp_s);
    check("valid", int'(valid_o), exp_v);
    check("wrap", int'(wrap_o), exp_w);
  endtask

  initial begin
    vec_t vecs[8];
    int   wraps, first_s, seen, lows;

    vecs[0] = '{64, 127};  vecs[1] = '{192, -127};
    vecs[2] = '{0, 0};     vecs[3] = '{128, 0};
    vecs[4] = '{32, 90};   vecs[5] = '{16, 49};
    vecs[6] = '{224, -90}; vecs[7] = '{96, 90};

    // Reset state
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_sample", int'(sample_o), 0);
    check("rst_valid", int'(valid_o), 0);
    check("rst_wrap", int'(wrap_o), 0);
    rst = 1'b0;

    // ftw=64: quarter-period steps, wrap every 4 steps
    ftw_i = 8'd64; ftw_load = 1'b1;
    tick();
    ftw_load = 1'b0; en = 1'b1;
    wraps = 0;
    repeat (16) begin tick(); wraps += int'(wrap_o); end
    check("wraps_ftw64", wraps, 4);

    // ftw=5 from a clean phase for 600 steps
    ftw_i = 8'd5; ftw_load = 1'b1; sync_clr = 1'b1;
    tick();
    ftw_load = 1'b0; sync_clr = 1'b0;
    wraps = 0; seen = 0; first_s = -999;
    repeat (600) begin
      tick();
      wraps += int'(wrap_o);
      if (valid_o && !seen) begin seen = 1; first_s = int'(sample_o); end
    end
    check("wraps_ftw5", wraps, 11);
    check("first_ftw5", first_s, 0);

    // ftw=0: constant sample selected purely by the phase offset
    ftw_i = '0; ftw_load = 1'b1; sync_clr = 1'b1;
    tick();
    ftw_load = 1'b0; sync_clr = 1'b0;
    foreach (vecs[i]) begin
      phase_off_i = PW'(vecs[i].off);
      tick(); tick();
      check("off_sample", int'(sample_o), vecs[i].exp_sample);
      check("off_valid", int'(valid_o), 1);
    end

    // Mid-run sync_clr together with a new tuning word
    phase_off_i = '0; ftw_i = 8'd7; ftw_load = 1'b1;
    tick();
    ftw_load = 1'b0;
    repeat (10) tick();
    sync_clr = 1'b1; ftw_load = 1'b1; ftw_i = 8'd32;
    tick();
    check("sync_nowrap", int'(wrap_o), 0);
    sync_clr = 1'b0; ftw_load = 1'b0;
    tick(); tick();
    check("sync_sample0", int'(sample_o), 0);
    tick();
    check("sync_sample1", int'(sample_o), 90);

    // en low for 3 cycles: exactly 3 invalid samples, phase held
    en = 1'b0;
    lows = 0;
    repeat (3) begin tick(); lows += int'(!valid_o); end
    en = 1'b1;
    repeat (5) begin tick(); lows += int'(!valid_o); end
    check("en_gap", lows, 3);

    // Randomized mix of all controls
    repeat (400) begin
      en          = ($urandom % 4) != 0;
      sync_clr    = ($urandom % 32) == 0;
      ftw_load    = ($urandom % 8) == 0;
      ftw_i       = PW'($urandom);
      phase_off_i = PW'($urandom);
      tick();
    end

    // Async reset between edges, then restart from phase 0
    en = 1'b1; sync_clr = 1'b0; ftw_load = 1'b1; ftw_i = 8'd64; phase_off_i = 8'd64;
    repeat (3) tick();
    ftw_load = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_sample", int'(sample_o), 0);
    check("arst_valid", int'(valid_o), 0);
    check("arst_wrap", int'(wrap_o), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0; phase_off_i = '0;
    tick(); tick();
    check("arst_first_valid", int'(valid_o), 1);
    check("arst_first_sample", int'(sample_o), 0);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
